// File: rtl/pool2d_stream_if.sv
// Memory-side ports of the pooling engine: a 1-cycle-latency read port
// feeding the window scan and a valid/ready write port for pooled results.
interface pool2d_stream_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int IDX_W  = 2
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              wr_en;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [IDX_W-1:0]  wr_idx;

    modport master (
        output rd_en, rd_addr,
        input  rd_data,
        output wr_en, wr_addr, wr_data, wr_idx,
        input  wr_ready
    );

    modport slave (
        input  rd_en, rd_addr,
        output rd_data,
        input  wr_en, wr_addr, wr_data, wr_idx,
        output wr_ready
    );
endinterface

// File: rtl/pool2d_stream.sv
// Streaming 2-D pooling engine: scans each KERNELxKERNEL window of every
// channel plane, folds signed max (with argmax offset) or average, and
// writes one result per window through a handshaked port.
//
// state | meaning
// IDLE  | waiting for start
// READ  | issuing one window read per cycle, j fastest then i
// DRAIN | folding the last returned element, result registered on exit
// WRITE | holding the result until the sink accepts it
// DONE  | one-cycle done pulse, then back to IDLE
module pool2d_stream #(
    parameter int DATA_W   = 16,
    parameter int FM_H     = 62,
    parameter int FM_W     = 62,
    parameter int CHANNELS = 1,
    parameter int KERNEL   = 2,
    parameter int STRIDE   = 2,
    parameter int ADDR_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 mode,
    pool2d_stream_if.master      mem,
    output logic                 busy,
    output logic                 done
);
    localparam int OUT_H = (FM_H - KERNEL) / STRIDE + 1;
    localparam int OUT_W = (FM_W - KERNEL) / STRIDE + 1;
    localparam int KK    = KERNEL * KERNEL;
    localparam int IDX_W = (KK > 1) ? $clog2(KK) : 1;
    localparam int SH    = 2 * $clog2(KERNEL);
    localparam int SUM_W = DATA_W + SH + 1;

    localparam logic [15:0]      K_LAST  = 16'(KERNEL - 1);
    localparam logic [15:0]      OX_LAST = 16'(OUT_W - 1);
    localparam logic [15:0]      OY_LAST = 16'(OUT_H - 1);
    localparam logic [15:0]      C_LAST  = 16'(CHANNELS - 1);
    localparam logic [IDX_W-1:0] KK_LAST = IDX_W'(KK - 1);

    typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, DONE} state_t;

    state_t                    state;
    logic                      mode_q;
    logic [15:0]               cnt_c, cnt_oy, cnt_ox, cnt_i, cnt_j;
    logic [IDX_W-1:0]          cnt_k;
    logic [15:0]               nxt_c, nxt_oy, nxt_ox, nxt_i, nxt_j;
    logic                      last_win;

    logic                      rd_vld_q;
    logic [IDX_W-1:0]          fold_k_q;
    logic signed [DATA_W-1:0]  sample;
    logic signed [DATA_W-1:0]  max_q, max_n;
    logic [IDX_W-1:0]          idx_q, idx_n;
    logic signed [SUM_W-1:0]   sum_q, sum_n;
    logic signed [DATA_W-1:0]  avg_res;

    function automatic logic [ADDR_W-1:0] in_addr(input logic [15:0] c, oy, ox, i, j);
        int a;
        a = int'(c) * FM_H * FM_W + (int'(oy) * STRIDE + int'(i)) * FM_W
            + int'(ox) * STRIDE + int'(j);
        return ADDR_W'(a);
    endfunction

    function automatic logic [ADDR_W-1:0] out_addr(input logic [15:0] c, oy, ox);
        int a;
        a = int'(c) * OUT_H * OUT_W + int'(oy) * OUT_W + int'(ox);
        return ADDR_W'(a);
    endfunction

    // Next in-window offset and next window position (ox, then oy, then channel).
    always_comb begin
        nxt_j = cnt_j + 16'd1;
        nxt_i = cnt_i;
        if (cnt_j == K_LAST) begin
            nxt_j = 16'd0;
            nxt_i = cnt_i + 16'd1;
        end
        nxt_ox = cnt_ox + 16'd1;
        nxt_oy = cnt_oy;
        nxt_c  = cnt_c;
        if (cnt_ox == OX_LAST) begin
            nxt_ox = 16'd0;
            nxt_oy = cnt_oy + 16'd1;
            if (cnt_oy == OY_LAST) begin
                nxt_oy = 16'd0;
                nxt_c  = cnt_c + 16'd1;
            end
        end
        last_win = (cnt_ox == OX_LAST) && (cnt_oy == OY_LAST) && (cnt_c == C_LAST);
    end

    // Fold the returning element; offset 0 seeds both accumulators so
    // all-negative windows pool correctly. Strict > keeps the earliest tie.
    always_comb begin
        sample = $signed(mem.rd_data);
        max_n  = max_q;
        idx_n  = idx_q;
        sum_n  = sum_q;
        if (rd_vld_q) begin
            if (fold_k_q == '0) begin
                max_n = sample;
                idx_n = '0;
                sum_n = SUM_W'(sample);
            end else begin
                if (sample > max_q) begin
                    max_n = sample;
                    idx_n = fold_k_q;
                end
                sum_n = sum_q + SUM_W'(sample);
            end
        end
        avg_res = DATA_W'(sum_n >>> SH);
    end

    // Read-return pipeline and accumulator registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_q <= 1'b0;
            fold_k_q <= '0;
            max_q    <= '0;
            idx_q    <= '0;
            sum_q    <= '0;
        end else begin
            rd_vld_q <= mem.rd_en;
            fold_k_q <= cnt_k;
            max_q    <= max_n;
            idx_q    <= idx_n;
            sum_q    <= sum_n;
        end
    end

    // Sequencing FSM with registered read/write/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mode_q      <= 1'b0;
            cnt_c       <= '0;
            cnt_oy      <= '0;
            cnt_ox      <= '0;
            cnt_i       <= '0;
            cnt_j       <= '0;
            cnt_k       <= '0;
            mem.rd_en   <= 1'b0;
            mem.rd_addr <= '0;
            mem.wr_en   <= 1'b0;
            mem.wr_addr <= '0;
            mem.wr_data <= '0;
            mem.wr_idx  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q      <= mode;
                        busy        <= 1'b1;
                        cnt_c       <= '0;
                        cnt_oy      <= '0;
                        cnt_ox      <= '0;
                        cnt_i       <= '0;
                        cnt_j       <= '0;
                        cnt_k       <= '0;
                        mem.rd_en   <= 1'b1;
                        mem.rd_addr <= in_addr(16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
                        state       <= READ;
                    end
                end
                READ: begin
                    if (cnt_k == KK_LAST) begin
                        mem.rd_en <= 1'b0;
                        state     <= DRAIN;
                    end else begin
                        cnt_i       <= nxt_i;
                        cnt_j       <= nxt_j;
                        cnt_k       <= cnt_k + IDX_W'(1);
                        mem.rd_addr <= in_addr(cnt_c, cnt_oy, cnt_ox, nxt_i, nxt_j);
                    end
                end
                DRAIN: begin
                    mem.wr_en   <= 1'b1;
                    mem.wr_data <= mode_q ? avg_res : max_n;
                    mem.wr_idx  <= mode_q ? '0 : idx_n;
                    mem.wr_addr <= out_addr(cnt_c, cnt_oy, cnt_ox);
                    state       <= WRITE;
                end
                WRITE: begin
                    if (mem.wr_ready) begin
                        mem.wr_en <= 1'b0;
                        if (last_win) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            cnt_c       <= nxt_c;
                            cnt_oy      <= nxt_oy;
                            cnt_ox      <= nxt_ox;
                            cnt_i       <= '0;
                            cnt_j       <= '0;
                            cnt_k       <= '0;
                            mem.rd_en   <= 1'b1;
                            mem.rd_addr <= in_addr(nxt_c, nxt_oy, nxt_ox, 16'd0, 16'd0);
                            state       <= READ;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pool2d_stream.sv
// Directed bench for pool2d_stream: a 4x4x1 K=2 S=2 instance and a
// 5x5x2 K=3 S=2 instance, each behind a 1-cycle-latency memory model.
module tb_pool2d_stream;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, mode, wr_ready, sel_b;
    logic busy_a, done_a, busy_b, done_b;
    logic start_a, start_b;

    pool2d_stream_if #(.DATA_W(16), .ADDR_W(16), .IDX_W(2)) ifa ();
    pool2d_stream_if #(.DATA_W(16), .ADDR_W(16), .IDX_W(4)) ifb ();

    assign start_a = start & ~sel_b;
    assign start_b = start & sel_b;
    assign ifa.wr_ready = wr_ready;
    assign ifb.wr_ready = wr_ready;

    pool2d_stream #(.DATA_W(16), .FM_H(4), .FM_W(4), .CHANNELS(1),
                    .KERNEL(2), .STRIDE(2), .ADDR_W(16)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .mode(mode),
        .mem(ifa.master), .busy(busy_a), .done(done_a));

    pool2d_stream #(.DATA_W(16), .FM_H(5), .FM_W(5), .CHANNELS(2),
                    .KERNEL(3), .STRIDE(2), .ADDR_W(16)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .mode(mode),
        .mem(ifb.master), .busy(busy_b), .done(done_b));

    logic [15:0] mem_a [0:15];
    logic [15:0] mem_b [0:63];

    always @(posedge clk) if (ifa.rd_en) ifa.rd_data <= mem_a[ifa.rd_addr[3:0]];
    always @(posedge clk) if (ifb.rd_en) ifb.rd_data <= mem_b[ifb.rd_addr[5:0]];

    logic        o_rd_en, o_wr_en, o_busy, o_done;
    logic [15:0] o_wr_addr, o_wr_data;
    logic [3:0]  o_wr_idx;
    assign o_rd_en   = sel_b ? ifb.rd_en   : ifa.rd_en;
    assign o_wr_en   = sel_b ? ifb.wr_en   : ifa.wr_en;
    assign o_busy    = sel_b ? busy_b      : busy_a;
    assign o_done    = sel_b ? done_b      : done_a;
    assign o_wr_addr = sel_b ? ifb.wr_addr : ifa.wr_addr;
    assign o_wr_data = sel_b ? ifb.wr_data : ifa.wr_data;
    assign o_wr_idx  = sel_b ? ifb.wr_idx  : {2'b00, ifa.wr_idx};

    int q_addr[$], q_data[$], q_idx[$];
    always @(posedge clk) begin
        if (o_wr_en && wr_ready) begin
            q_addr.push_back(int'(o_wr_addr));
            q_data.push_back(int'($signed(o_wr_data)));
            q_idx.push_back(int'(o_wr_idx));
        end
    end

    int exp_data[8];
    int exp_idx[8];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic set_exp4(input int d0, input int d1, input int d2, input int d3, input int idx);
        exp_data[0] = d0; exp_data[1] = d1; exp_data[2] = d2; exp_data[3] = d3;
        for (int i = 0; i < 4; i++) exp_idx[i] = idx;
    endtask

    task automatic run_pass(input string name, input logic m, input bit bp, input bit abort,
                            input int n_out, input int exp_cycles);
        int n, hold, done_n, done_cnt, bad;
        logic [15:0] h_addr, h_data;
        q_addr.delete(); q_data.delete(); q_idx.delete();
        @(negedge clk); mode = m; start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0; hold = 0; done_n = -1; done_cnt = 0; bad = 0;
        h_addr = '0; h_data = '0;
        check_val({name, " busy_after_start"}, int'(o_busy), 1);
        while (n < 400) begin
            @(negedge clk);
            n++;
            wr_ready = 1'b1;
            start    = 1'b0;
            if (o_done) begin
                done_cnt++;
                if (done_n < 0) done_n = n;
                check_val({name, " busy_at_done"}, int'(o_busy), 0);
            end
            if (abort && q_addr.size() == 1 && o_rd_en) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check_val({name, " rd_en_after_rst"}, int'(o_rd_en), 0);
                check_val({name, " wr_en_after_rst"}, int'(o_wr_en), 0);
                check_val({name, " busy_after_rst"}, int'(o_busy), 0);
                check_val({name, " done_after_rst"}, int'(o_done), 0);
                repeat (20) begin
                    @(negedge clk);
                    if (o_done || o_rd_en || o_wr_en) bad++;
                end
                check_val({name, " quiet_after_rst"}, bad, 0);
                check_val({name, " writes_before_rst"}, q_addr.size(), 1);
                return;
            end
            if (bp && o_wr_en && q_addr.size() == 1 && hold < 5) begin
                if (hold == 0) begin
                    h_addr = o_wr_addr;
                    h_data = o_wr_data;
                    start  = 1'b1;
                end else begin
                    check_val({name, " held_addr"}, int'(o_wr_addr), int'(h_addr));
                    check_val({name, " held_data"}, int'(o_wr_data), int'(h_data));
                    check_val({name, " held_wr_en"}, int'(o_wr_en), 1);
                end
                check_val({name, " rd_en_in_hold"}, int'(o_rd_en), 0);
                wr_ready = 1'b0;
                hold++;
            end
            if (done_n > 0 && n >= done_n + 3) break;
        end
        check_val({name, " done_count"}, done_cnt, 1);
        check_val({name, " done_cycle"}, done_n, exp_cycles);
        check_val({name, " write_count"}, q_addr.size(), n_out);
        for (int i = 0; i < n_out && i < q_addr.size(); i++) begin
            check_val($sformatf("%s addr[%0d]", name, i), q_addr[i], i);
            check_val($sformatf("%s data[%0d]", name, i), q_data[i], exp_data[i]);
            check_val($sformatf("%s idx[%0d]", name, i), q_idx[i], exp_idx[i]);
        end
    endtask

    initial begin
        int m3[16];
        m3 = '{-1, -2, 7, 7, -3, -4, 7, 7,
               -32768, -32768, 32767, 32767, -32768, -32768, 32767, 32767};
        rst = 1'b1; start = 1'b0; mode = 1'b0; wr_ready = 1'b1; sel_b = 1'b0;
        for (int i = 0; i < 16; i++) mem_a[i] = 16'(i);
        for (int i = 0; i < 64; i++) mem_b[i] = 16'(i);
        mem_b[6]  = 16'd100;
        mem_b[25] = 16'd37;

        repeat (3) @(negedge clk);
        check_val("rst rd_en",   int'(ifa.rd_en), 0);
        check_val("rst wr_en",   int'(ifa.wr_en), 0);
        check_val("rst busy",    int'(busy_a), 0);
        check_val("rst done",    int'(done_a), 0);
        check_val("rst rd_addr", int'(ifa.rd_addr), 0);
        check_val("rst wr_addr", int'(ifa.wr_addr), 0);
        check_val("rst wr_data", int'(ifa.wr_data), 0);
        check_val("rst wr_idx",  int'(ifa.wr_idx), 0);
        rst = 1'b0;

        set_exp4(5, 7, 13, 15, 3);
        run_pass("max_inc", 1'b0, 1'b0, 1'b0, 4, 24);

        for (int i = 0; i < 16; i++) mem_a[i] = 16'(-i);
        set_exp4(0, -2, -8, -10, 0);
        run_pass("max_neg", 1'b0, 1'b0, 1'b0, 4, 24);

        for (int i = 0; i < 16; i++) mem_a[i] = 16'(i);
        set_exp4(2, 4, 10, 12, 0);
        run_pass("avg_inc", 1'b1, 1'b0, 1'b0, 4, 24);

        for (int i = 0; i < 16; i++) mem_a[i] = 16'(m3[i]);
        set_exp4(-3, 7, -32768, 32767, 0);
        run_pass("avg_edge", 1'b1, 1'b0, 1'b0, 4, 24);
        set_exp4(-1, 7, -32768, 32767, 0);
        run_pass("max_tie", 1'b0, 1'b0, 1'b0, 4, 24);

        for (int i = 0; i < 16; i++) mem_a[i] = 16'(i);
        set_exp4(5, 7, 13, 15, 3);
        run_pass("max_bp", 1'b0, 1'b1, 1'b0, 4, 29);
        run_pass("abort", 1'b0, 1'b0, 1'b1, 4, 24);
        run_pass("after_rst", 1'b0, 1'b0, 1'b0, 4, 24);

        sel_b = 1'b1;
        exp_data = '{100, 14, 22, 24, 37, 39, 47, 49};
        exp_idx  = '{4, 8, 8, 8, 0, 8, 8, 8};
        run_pass("k3_2ch", 1'b0, 1'b0, 1'b0, 8, 88);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
